motion_tracker: RTL

MOTION_TRACKER -- requirements
Module: motion_tracker

---
 rtl/motion_pkg.sv | 23 ++
 rtl/tick_gen.sv | 29 ++
 rtl/motion_tracker.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/motion_pkg.sv
// Shared definitions for the motion tracker: FSM state encoding and
// width helpers used to size the prescaler and datapath.
package motion_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_DONE
  } state_e;

  // Number of bits needed to hold v (at least 1).
  function automatic int unsigned bits_for(input longint unsigned v);
    int unsigned b;
    b = 1;
    while (b < 64 && (v >> b) != 0) b++;
    return b;
  endfunction

  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: counts 0..C_CLKFREQ-1 while enabled, tick on the last count.
module tick_gen
  import motion_pkg::*;
#(
  parameter int unsigned C_CLKFREQ = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = bits_for(longint'(C_CLKFREQ) - 1);
  localparam logic [CW-1:0] LAST = CW'(C_CLKFREQ - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/motion_tracker.sv
// Moves a position toward a destination one velocity step per second,
// with clamping at the destination, a seconds-based timeout and abort.
module motion_tracker
  import motion_pkg::*;
#(
  parameter int unsigned C_CLKFREQ   = 100000000,
  parameter int unsigned C_POS_W     = 10,
  parameter int unsigned C_VEL_W     = 8,
  parameter int unsigned C_TIME_W    = 16,
  parameter int unsigned C_TIMEOUT_S = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [C_POS_W-1:0]  start_pos_i,
  input  logic [C_POS_W-1:0]  dest_pos_i,
  input  logic [C_VEL_W-1:0]  start_vel_i,
  input  logic [C_VEL_W-1:0]  vel_i,
  output logic                busy_o,
  output logic                dir_o,
  output logic [C_POS_W-1:0]  pos_o,
  output logic                reached_o,
  output logic                timeout_o,
  output logic                done_o,
  output logic [C_TIME_W-1:0] dest_reach_second_o
);

  localparam int unsigned AW = max_w(C_POS_W + 1, C_VEL_W + 1);

  state_e               state_q, state_d;
  logic [C_POS_W-1:0]   pos_q, pos_d, dest_q, dest_d;
  logic [C_VEL_W-1:0]   svel_q, svel_d;
  logic                 dir_q, dir_d;
  logic                 reached_q, reached_d, timeout_q, timeout_d, done_q, done_d;
  logic [C_TIME_W-1:0]  sec_q, sec_d, reach_sec_q, reach_sec_d, sec_inc;
  logic [AW-1:0]        pos_a, dest_a, dist_a, step_a, next_a;
  logic                 tick, tick_clr, timeout_hit;

  tick_gen #(
    .C_CLKFREQ(C_CLKFREQ)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q == ST_MOVE),
    .clr_i (tick_clr),
    .tick_o(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    dest_d      = dest_q;
    svel_d      = svel_q;
    dir_d       = dir_q;
    reached_d   = reached_q;
    timeout_d   = timeout_q;
    done_d      = 1'b0;
    sec_d       = sec_q;
    reach_sec_d = reach_sec_q;
    tick_clr    = 1'b0;

    // The seconds counter is still zero only before the first tick.
    pos_a       = AW'(pos_q);
    dest_a      = AW'(dest_q);
    dist_a      = dir_q ? (dest_a - pos_a) : (pos_a - dest_a);
    step_a      = (sec_q == '0) ? AW'(svel_q) : AW'(vel_i);
    next_a      = dir_q ? (pos_a + step_a) : (pos_a - step_a);
    sec_inc     = (&sec_q) ? sec_q : sec_q + 1'b1;
    timeout_hit = (64'(sec_inc) >= 64'(C_TIMEOUT_S));

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          pos_d       = start_pos_i;
          dest_d      = dest_pos_i;
          svel_d      = start_vel_i;
          dir_d       = (dest_pos_i >= start_pos_i);
          reached_d   = 1'b0;
          timeout_d   = 1'b0;
          reach_sec_d = '0;
          sec_d       = '0;
          tick_clr    = 1'b1;
          state_d     = ST_MOVE;
        end
      end
      ST_MOVE: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (pos_q == dest_q) begin
          reached_d   = 1'b1;
          done_d      = 1'b1;
          reach_sec_d = sec_q;
          state_d     = ST_DONE;
        end else if (tick) begin
          sec_d = sec_inc;
          if (dist_a <= step_a) begin
            pos_d       = dest_q;
            reached_d   = 1'b1;
            reach_sec_d = sec_inc;
            done_d      = 1'b1;
            state_d     = ST_DONE;
          end else begin
            pos_d = next_a[C_POS_W-1:0];
            if (timeout_hit) begin
              timeout_d = 1'b1;
              done_d    = 1'b1;
              state_d   = ST_DONE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q       <= '0;
      dest_q      <= '0;
      svel_q      <= '0;
      dir_q       <= 1'b1;
      reached_q   <= 1'b0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
      sec_q       <= '0;
      reach_sec_q <= '0;
    end else begin
      pos_q       <= pos_d;
      dest_q      <= dest_d;
      svel_q      <= svel_d;
      dir_q       <= dir_d;
      reached_q   <= reached_d;
      timeout_q   <= timeout_d;
      done_q      <= done_d;
      sec_q       <= sec_d;
      reach_sec_q <= reach_sec_d;
    end
  end

  assign busy_o              = (state_q == ST_MOVE);
  assign dir_o               = dir_q;
  assign pos_o               = pos_q;
  assign reached_o           = reached_q;
  assign timeout_o           = timeout_q;
  assign done_o              = done_q;
  assign dest_reach_second_o = reach_sec_q;

endmodule
